naive_fntt_iter: RTL and testbench

//  Parametrised iterative forward NTT core: N-point, W-bit, radix-2 DIT over Z_mod.

---
 rtl/naive_fntt_iter.sv | 151 +++++++++++++++
 tb/tb_naive_fntt_iter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/naive_fntt_iter.sv
// Iterative radix-2 DIT forward NTT: loads N coefficients bit-reversed, builds twiddles,
// runs LOGN stages on one shared butterfly, streams results out in natural order.
module naive_fntt_iter #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] omega,
  input  logic [W-1:0] mod,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_TWID   = 3'd2;
  localparam logic [2:0] S_COMP   = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;

  localparam logic [LOGN-1:0] LAST       = LOGN'(N - 1);
  localparam logic [LOGN-1:0] TW_LAST    = LOGN'(N / 2 - 1);
  localparam logic [LOGN-2:0] BF_LAST    = {(LOGN-1){1'b1}};
  localparam logic [LOGN-1:0] LAST_STAGE = LOGN'(LOGN - 1);

  logic [2:0]      state;
  logic [W-1:0]    q;
  logic [W-1:0]    w_om;
  logic [LOGN-1:0] cnt;
  logic [LOGN-2:0] bfly;
  logic [LOGN-1:0] stage;

  logic [W-1:0] ram [N];
  logic [W-1:0] tw  [N/2];

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
    return r;
  endfunction

  logic [LOGN-1:0] half, k_idx, top, bot;
  logic [LOGN-2:0] tw_sel;
  logic [W-1:0]    a, b, w, t, new_top, new_bot;
  logic [2*W-1:0]  prod;
  logic [W:0]      sum, dif;
  logic [W-1:0]    tw_prev, tw_next, ld_val;
  logic [2*W-1:0]  tw_prod;

  // Butterfly j of stage s: group base is j with bit s shifted up, k is j's low s bits.
  always_comb begin
    half    = LOGN'(1) << stage;
    k_idx   = {1'b0, bfly} & (half - LOGN'(1));
    top     = (({1'b0, bfly} >> stage) << (stage + LOGN'(1))) | k_idx;
    bot     = top | half;
    tw_sel  = (LOGN-1)'(k_idx << (LAST_STAGE - stage));
    a       = ram[top];
    b       = ram[bot];
    w       = tw[tw_sel];
    prod    = {{W{1'b0}}, w} * {{W{1'b0}}, b};
    t       = W'(prod % {{W{1'b0}}, q});
    // a and t are both < q, so a single conditional subtract reduces the sums.
    sum     = {1'b0, a} + {1'b0, t};
    dif     = {1'b0, a} + {1'b0, q} - {1'b0, t};
    new_top = (sum >= {1'b0, q}) ? W'(sum - {1'b0, q}) : W'(sum);
    new_bot = (dif >= {1'b0, q}) ? W'(dif - {1'b0, q}) : W'(dif);
    tw_prev = tw[cnt[LOGN-2:0] - (LOGN-1)'(1)];
    tw_prod = {{W{1'b0}}, tw_prev} * {{W{1'b0}}, w_om};
    tw_next = (cnt == '0) ? W'(1) : W'(tw_prod % {{W{1'b0}}, q});
    ld_val  = in_data % q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      q     <= '0;
      w_om  <= '0;
      cnt   <= '0;
      bfly  <= '0;
      stage <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          q     <= mod;
          w_om  <= omega;
          cnt   <= '0;
          bfly  <= '0;
          stage <= '0;
          state <= S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          cnt <= cnt + LOGN'(1);
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_TWID;
          end
        end
        S_TWID: begin
          cnt <= cnt + LOGN'(1);
          if (cnt == TW_LAST) begin
            cnt   <= '0;
            state <= S_COMP;
          end
        end
        S_COMP: begin
          bfly <= bfly + (LOGN-1)'(1);
          if (bfly == BF_LAST) begin
            stage <= stage + LOGN'(1);
            if (stage == LAST_STAGE) begin
              stage <= '0;
              state <= S_UNLOAD;
            end
          end
        end
        S_UNLOAD: if (out_ready) begin
          cnt <= cnt + LOGN'(1);
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_valid) ram[bitrev(cnt)] <= ld_val;
    if (state == S_TWID) tw[cnt[LOGN-2:0]] <= tw_next;
    if (state == S_COMP) begin
      ram[top] <= new_top;
      ram[bot] <= new_bot;
    end
  end

  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_UNLOAD);
  assign busy      = (state != S_IDLE);
  assign out_data  = out_valid ? ram[cnt] : '0;
  assign done      = out_valid && out_ready && (cnt == LAST);

endmodule

// File: tb/tb_naive_fntt_iter.sv
// Scoreboard bench for naive_fntt_iter: a direct O(N^2) NTT model fills the expected queue,
// a negedge monitor pops and compares every output handshake.
module tb_naive_fntt_iter;
  localparam int N = 8;
  localparam int W = 8;

  logic         clk = 0;
  logic         rst = 1;
  logic         start = 0;
  logic [W-1:0] omega = 0, mod = 0;
  logic         in_valid = 0;
  logic [W-1:0] in_data = 0;
  logic         in_ready, out_valid, busy, done;
  logic [W-1:0] out_data;
  logic         out_ready = 1;

  naive_fntt_iter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .omega(omega), .mod(mod),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int exp_q[$];
  int xv[N];
  int q_m = 17, om_m = 9;
  int mon_idx = 0, done_cnt = 0;
  int t_start = 0, t_first = 0;
  bit arm = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_data = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  function automatic int powmod(input int b, input int e, input int m);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  task automatic push_model();
    for (int k = 0; k < N; k++) begin
      int acc = 0;
      for (int j = 0; j < N; j++)
        acc = (acc + (xv[j] % q_m) * powmod(om_m, j * k, q_m)) % q_m;
      exp_q.push_back(acc);
    end
  endtask

  // Monitor: every handshake is checked against the scoreboard; held data checked while stalled.
  initial forever begin
    @(negedge clk);
    if (arm && out_valid) begin
      t_first = cyc;
      arm = 0;
    end
    if (done) done_cnt++;
    if (prev_stall) chk("hold", out_data, prev_data);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk($sformatf("X[%0d]", mon_idx), out_data, exp_q.pop_front());
      chk("done_flag", done, (mon_idx == N - 1) ? 1 : 0);
      mon_idx = (mon_idx + 1) % N;
    end
  end

  // Pulses start in the current cycle, pushes the model result, then feeds N beats.
  task automatic begin_run(input bit gaps);
    omega = W'(om_m); mod = W'(q_m); start = 1;
    t_start = cyc; arm = 1;
    push_model();
    @(posedge clk); #1;
    start = 0; omega = 8'hA5; mod = 8'h3C;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        in_valid = 0;
        for (int c = 0; c < g; c++) begin
          in_data = W'($urandom);
          @(posedge clk); #1;
        end
      end
      for (int c = 0; c < 50 && !in_ready; c++) begin
        @(posedge clk); #1;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      in_valid = 1; in_data = W'(xv[i]);
      @(posedge clk); #1;
    end
    in_valid = 0; in_data = W'($urandom);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 500 && (exp_q.size() != 0 || busy); c++) @(posedge clk);
    #1;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic set_x(input int a0, a1, a2, a3, a4, a5, a6, a7);
    xv = '{a0, a1, a2, a3, a4, a5, a6, a7};
  endtask

  initial begin
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;

    // Impulse: all-ones spectrum, latency and single done pulse.
    set_x(1, 0, 0, 0, 0, 0, 0, 0);
    done_cnt = 0;
    begin_run(0);
    drain("impulse");
    chk("latency", t_first - t_start, N + N / 2 + 3 * N / 2 + 1);
    chk("done_count", done_cnt, 1);

    set_x(0, 1, 0, 0, 0, 0, 0, 0);
    begin_run(0); drain("shift");
    set_x(1, 1, 1, 1, 1, 1, 1, 1);
    begin_run(0); drain("ones");
    set_x(18, 18, 18, 18, 18, 18, 18, 18);
    begin_run(0); drain("reduce");

    // Input gaps plus a 3-cycle consumer stall mid-unload.
    set_x(3, 14, 7, 0, 16, 5, 9, 2);
    begin_run(1);
    for (int c = 0; c < 200 && mon_idx != 3; c++) @(posedge clk);
    #1 out_ready = 0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1;
    drain("stall");

    // start pulsed during COMP with different parameters must be ignored.
    set_x(5, 4, 3, 2, 1, 0, 16, 15);
    begin_run(0);
    repeat (6) @(posedge clk);
    #1 start = 1; omega = 8'd3; mod = 8'd200;
    @(posedge clk); #1 start = 0;
    drain("start_ignored");

    // Reset mid-COMP aborts the run; its expected values are discarded.
    set_x(1, 2, 3, 4, 5, 6, 7, 8);
    begin_run(0);
    repeat (7) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    @(posedge clk); #1 rst = 0;
    exp_q.delete();
    mon_idx = 0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) xv[i] = $urandom_range(0, 255);
    begin_run(0); drain("after_reset");

    // Back-to-back: second start in the cycle right after done.
    for (int i = 0; i < N; i++) xv[i] = $urandom_range(0, 16);
    begin_run(0);
    begin
      int c;
      for (c = 0; c < 200 && !done; c++) @(negedge clk);
      chk("b2b_done_seen", done, 1);
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) xv[i] = $urandom_range(0, 255);
    begin_run(1); drain("back_to_back");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d want 0", 1);
    $fatal(1);
  end
endmodule
